// File: rtl/tdm_scheduler.sv
// Round-robin TDM serialiser: CHANNELS lanes of WIDTH bits share one registered output,
// each enabled channel holding the output for SLOT_CYCLES clocks; masked channels are skipped.
module tdm_scheduler #(
  parameter int WIDTH       = 2,
  parameter int CHANNELS    = 4,
  parameter int SLOT_CYCLES = 1,
  parameter int IDXW        = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       ch_mask,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [IDXW-1:0]           slot_idx,
  output logic                      frame_start
);

  localparam int DW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SLOT_CYCLES - 1);

  // Smallest enabled index above p, wrapping to the smallest enabled index overall.
  function automatic logic [IDXW-1:0] next_en(input logic [IDXW-1:0] p,
                                              input logic [CHANNELS-1:0] m);
    logic [IDXW-1:0] hi;
    logic [IDXW-1:0] lo;
    logic            hit;
    hi  = p;
    lo  = p;
    hit = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lo = IDXW'(i);
        if (i > int'(p)) begin
          hi  = IDXW'(i);
          hit = 1'b1;
        end
      end
    end
    return hit ? hi : lo;
  endfunction

  function automatic logic [IDXW-1:0] first_en(input logic [CHANNELS-1:0] m);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = IDXW'(i);
      end
    end
    return r;
  endfunction

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             run_s;
  logic [IDXW-1:0]  chan_s;
  logic [DW-1:0]    eff_dwell_s;

  assign run_s = en & (|ch_mask);

  // Pick the emitting channel and advance the slot/dwell pointers.
  always_comb begin
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    chan_s      = ch_mask[ptr_q] ? ptr_q : next_en(ptr_q, ch_mask);
    eff_dwell_s = (chan_s == ptr_q) ? dwell_q : '0;
    if (run_s) begin
      out_d   = in_bus[chan_s*WIDTH +: WIDTH];
      idx_d   = chan_s;
      valid_d = 1'b1;
      fs_d    = (eff_dwell_s == '0) && (chan_s == first_en(ch_mask));
      if (eff_dwell_s == DWELL_LAST) begin
        dwell_d = '0;
        ptr_d   = next_en(chan_s, ch_mask);
      end else begin
        dwell_d = eff_dwell_s + DW'(1);
        ptr_d   = chan_s;
      end
    end else begin
      ptr_d   = ptr_q;
      dwell_d = dwell_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = valid_q;
  assign slot_idx    = idx_q;
  assign frame_start = fs_q;

endmodule

// File: doc/tdm_scheduler.md
# tdm_scheduler

Parametrised time-division multiplexer that serialises CHANNELS input lanes of WIDTH bits onto one registered output lane, one channel per slot of SLOT_CYCLES clocks. It generalises the fixed 4x2-bit round-robin TDM: per-channel enable mask with slot skipping, configurable slot dwell, a global run enable, and valid / slot-index / frame-start sideband for the downstream deframer.

## Interface
- WIDTH, 2, bits per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SLOT_CYCLES, 1, clocks each channel is held on the output (>=1)
- IDXW, $clog2(CHANNELS), width of slot index (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_bus  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- en  in  1  run enable
- ch_mask  in  CHANNELS  bit k=1 includes channel k in the rotation
- out  out  WIDTH  registered channel data
- out_valid  out  1  out carries a live slot
- slot_idx  out  IDXW  channel index currently on out
- frame_start  out  1  first cycle of the first slot of a frame

## Operation
- Internal state: ptr (IDXW, channel owning current/next slot), dwell (counts 0..SLOT_CYCLES-1).
- next_en(p): smallest enabled index > p; if none, smallest enabled index overall (wrap); equals p if p is the only enabled channel.
- first_en: smallest enabled index in ch_mask.
- run = en & (|ch_mask).
- Each rising edge with run=1:
  - emit channel c = ch_mask[ptr] ? ptr : next_en(ptr); effective dwell d = (c==ptr) ? dwell : 0.
  - out <= in_bus[c], slot_idx <= c, out_valid <= 1.
  - frame_start <= (d==0) && (c==first_en).
  - if d==SLOT_CYCLES-1: dwell <= 0, ptr <= next_en(c); else dwell <= d+1, ptr <= c.
- Each rising edge with run=0: ptr and dwell hold; out and slot_idx hold last value; out_valid <= 0; frame_start <= 0. On resume the interrupted slot continues with its remaining dwell (if channel still enabled).
- Masked channels never appear on out; ch_mask is sampled every edge, changes take effect at the next edge.
- Current channel disabled mid-dwell: slot abandoned at next edge, next enabled channel starts with dwell 0.
- Single enabled channel: that channel emitted every cycle; frame_start pulses every SLOT_CYCLES cycles.
- in_bus sampled at the edge that emits it; mid-slot input changes propagate (out follows in_bus[c] each cycle of the slot).

## Timing
- Reset (async assert, any time): out=0, out_valid=0, slot_idx=0, frame_start=0, ptr=0, dwell=0. Takes effect immediately, no clock required; release synchronous to next edge.
- Latency: 1 clock from in_bus / ch_mask / en to outputs; all outputs registered, no combinational path input->output.
- Frame length = SLOT_CYCLES x popcount(ch_mask) cycles while mask stable.
- First edge after reset release with run=1 emits first_en with frame_start=1.
- Reset mid-slot: slot discarded, rotation restarts from first_en.

## Test plan
- Reset: WIDTH=2, CHANNELS=4, SLOT_CYCLES=1, in_bus={11,10,01,00}, rst=1 -> out=00, out_valid=0, slot_idx=0, frame_start=0 without clock edges; release, en=1, mask=1111 -> out 00,01,10,11,00,... slot_idx 0,1,2,3,0, frame_start on each slot 0.
- Skip: mask=1010 -> slot_idx 1,3,1,3; out 01,11,...; frame_start on each slot_idx=1 cycle; channels 0,2 never on out.
- Dwell: SLOT_CYCLES=3, mask=1111 -> each slot_idx held 3 cycles, frame 12 cycles, frame_start only on first cycle of slot 0.
- Pause: SLOT_CYCLES=3, drop en for 2 cycles after 1st cycle of slot 2 -> out_valid=0 for 2 cycles, out holds 10; on resume slot 2 lasts 2 more cycles, then slot 3.
- Mask edge cases: mask=0000 -> out_valid=0, state frozen; mask=0100 -> slot_idx=2 every cycle, frame_start every SLOT_CYCLES; clear mask bit of current channel mid-dwell -> next enabled channel on next cycle.
- Async reset mid-frame (between edges, during slot 2) -> outputs zero immediately; after release rotation restarts at first_en with frame_start=1.
